traffic_light_ctrl_param: RTL and testbench

//  Parametrised successor of the two-road (highway / local-road) light controller.
//  - Adds configurable phase durations, a min/max local-road green window and gap-out.
//  - Optionally adds a pedestrian phase.
//  - Moore FSM; one clock domain; drives the lamp outputs of the junction model directly.

---
 rtl/tlc_pkg.sv | 32 +++
 rtl/tlc_if.sv | 41 ++++
 rtl/tlc_phase_timer.sv | 38 +++
 rtl/traffic_light_ctrl_param.sv | 146 ++++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
//----------------------------------------------------------------------------
// Module   : tlc_pkg
// Brief    : Shared types, lamp constants and sizing helper for the
//            parametrised highway / local-road traffic light controller.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package tlc_pkg;

    typedef enum logic [2:0] {
        HW_G = 3'd0,
        HW_Y = 3'd1,
        AR1  = 3'd2,
        LR_G = 3'd3,
        LR_Y = 3'd4,
        AR2  = 3'd5,
        PED  = 3'd6
    } tlc_state_t;

    localparam logic [2:0] L_GREEN  = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_RED    = 3'b001;

    // Bits needed to hold 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_if.sv
//----------------------------------------------------------------------------
// Module   : tlc_if
// Brief    : Junction-side signals of the traffic light controller. The
//            pedestrian signals exist only when TLC_PED_EN is defined.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface tlc_if;
    logic       lr_has_car;
    logic [2:0] hw_light;
    logic [2:0] lr_light;
`ifdef TLC_PED_EN
    logic       ped_req;
    logic       ped_walk;
`endif

    // Junction model side: sensors out, lamps in.
    modport master (
        output lr_has_car,
`ifdef TLC_PED_EN
        output ped_req,
        input  ped_walk,
`endif
        input  hw_light,
        input  lr_light
    );

    // Controller side.
    modport slave (
        input  lr_has_car,
`ifdef TLC_PED_EN
        input  ped_req,
        output ped_walk,
`endif
        output hw_light,
        output lr_light
    );
endinterface

`default_nettype wire

// File: rtl/tlc_phase_timer.sv
//----------------------------------------------------------------------------
// Module   : tlc_phase_timer
// Brief    : Per-state cycle counter with synchronous clear, saturation and
//            a "reached limit-1" compare.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tlc_phase_timer #(
    parameter int CNT_W = 7
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic [CNT_W-1:0] i_limit,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_at_limit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt      = r_cnt;
    // Limits are always >= 1, so limit-1 never underflows.
    assign o_at_limit = (r_cnt >= (i_limit - 1'b1));

endmodule

`default_nettype wire

// File: rtl/traffic_light_ctrl_param.sv
//----------------------------------------------------------------------------
// Module   : traffic_light_ctrl_param
// Brief    : Moore traffic light controller, highway / local road, with
//            configurable phase lengths, local-road min/max green and gap-out.
//            Define TLC_PED_EN to add the pedestrian walk phase.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module traffic_light_ctrl_param
    import tlc_pkg::*;
#(
    parameter int HW_MIN_CYC = 70,
    parameter int LR_MIN_CYC = 10,
    parameter int LR_MAX_CYC = 70,
    parameter int YEL_CYC    = 25,
    parameter int RED_CYC    = 1,
    parameter int PED_CYC    = 20
) (
    input  wire logic clk,
    input  wire logic rst_n,
    tlc_if.slave      bus
);

    localparam int MAX_A  = (HW_MIN_CYC > LR_MAX_CYC) ? HW_MIN_CYC : LR_MAX_CYC;
    localparam int MAX_B  = (YEL_CYC > RED_CYC) ? YEL_CYC : RED_CYC;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P  = (MAX_C > PED_CYC) ? MAX_C : PED_CYC;
    localparam int CNT_W  = cnt_width(MAX_P);

    localparam logic [CNT_W-1:0] c_hw_lim  = CNT_W'(HW_MIN_CYC);
    localparam logic [CNT_W-1:0] c_lr_lim  = CNT_W'(LR_MIN_CYC);
    localparam logic [CNT_W-1:0] c_lr_max  = CNT_W'(LR_MAX_CYC - 1);
    localparam logic [CNT_W-1:0] c_yel_lim = CNT_W'(YEL_CYC);
    localparam logic [CNT_W-1:0] c_red_lim = CNT_W'(RED_CYC);
    localparam logic [CNT_W-1:0] c_ped_lim = CNT_W'(PED_CYC);

    generate
        if (HW_MIN_CYC < 1 || LR_MIN_CYC < 1 || LR_MAX_CYC < 1 || YEL_CYC < 1 ||
            RED_CYC < 1 || PED_CYC < 1 || LR_MIN_CYC > LR_MAX_CYC) begin : g_bad_params
            $error("traffic_light_ctrl_param: invalid phase duration parameters");
        end
    endgenerate

    tlc_state_t       r_state;
    tlc_state_t       w_next;
    logic [CNT_W-1:0] w_limit;
    logic [CNT_W-1:0] w_cnt;
    logic             w_at_limit;
    logic             w_pend;
    logic             w_lr_max;

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_next != r_state),
        .i_limit    (w_limit),
        .o_cnt      (w_cnt),
        .o_at_limit (w_at_limit)
    );

    // The counter clears on every state change, so == and >= agree here.
    assign w_lr_max = (w_cnt == c_lr_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HW_G;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef TLC_PED_EN
    logic r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (w_next == PED && r_state != PED) begin
            r_pend <= 1'b0;
        end else if (bus.ped_req && r_state != PED) begin
            r_pend <= 1'b1;
        end
    end

    assign w_pend = r_pend;
`else
    assign w_pend = 1'b0;
`endif

    always_comb begin
        w_next       = r_state;
        w_limit      = c_hw_lim;
        bus.hw_light = L_RED;
        bus.lr_light = L_RED;
`ifdef TLC_PED_EN
        bus.ped_walk = 1'b0;
`endif
        case (r_state)
            HW_G: begin
                w_limit      = c_hw_lim;
                bus.hw_light = L_GREEN;
                if (w_at_limit && (bus.lr_has_car || w_pend)) w_next = HW_Y;
            end
            HW_Y: begin
                w_limit      = c_yel_lim;
                bus.hw_light = L_YELLOW;
                if (w_at_limit) w_next = AR1;
            end
            AR1: begin
                w_limit = c_red_lim;
                if (w_at_limit) w_next = w_pend ? PED : LR_G;
            end
            LR_G: begin
                w_limit      = c_lr_lim;
                bus.lr_light = L_GREEN;
                if (w_lr_max || (w_at_limit && !bus.lr_has_car)) w_next = LR_Y;
            end
            LR_Y: begin
                w_limit      = c_yel_lim;
                bus.lr_light = L_YELLOW;
                if (w_at_limit) w_next = AR2;
            end
            AR2: begin
                w_limit = c_red_lim;
                if (w_at_limit) w_next = HW_G;
            end
`ifdef TLC_PED_EN
            PED: begin
                w_limit      = c_ped_lim;
                bus.ped_walk = 1'b1;
                if (w_at_limit) w_next = bus.lr_has_car ? LR_G : AR2;
            end
`endif
            default: begin
                w_limit = c_ped_lim;
                w_next  = HW_G;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_ctrl_param.sv
//----------------------------------------------------------------------------
// Module   : tb_traffic_light_ctrl_param
// Brief    : Directed self-checking bench; u_a uses default parameters,
//            u_b uses LR_MIN_CYC = LR_MAX_CYC = 5.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_traffic_light_ctrl_param;

    localparam logic [5:0] HWG  = 6'b100_001;
    localparam logic [5:0] HWY  = 6'b010_001;
    localparam logic [5:0] ALLR = 6'b001_001;
    localparam logic [5:0] LRG  = 6'b001_100;
    localparam logic [5:0] LRY  = 6'b001_010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic car = 1'b0;
    logic ped = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [5:0] rec_a [0:399];
    logic [5:0] rec_b [0:399];
    logic       rec_w [0:399];

    always #5 clk = ~clk;

    tlc_if if_a ();
    tlc_if if_b ();

    assign if_a.lr_has_car = car;
    assign if_b.lr_has_car = car;
`ifdef TLC_PED_EN
    assign if_a.ped_req = ped;
    assign if_b.ped_req = ped;
`endif

    traffic_light_ctrl_param u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    traffic_light_ctrl_param #(
        .LR_MIN_CYC (5),
        .LR_MAX_CYC (5)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Hold reset two cycles, check reset outputs, release at a falling edge (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        car   = 1'b0;
        ped   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_lamps", {26'd0, if_a.hw_light, if_a.lr_light}, {26'd0, HWG});
`ifdef TLC_PED_EN
        check("rst_walk", {31'd0, if_a.ped_walk}, 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    task automatic run_seq(input int n, input int car_from, input int car_to, input int ped_at);
        for (int k = 0; k < n; k++) begin
            car      = (k >= car_from) && (k < car_to);
            ped      = (k == ped_at);
            rec_a[k] = {if_a.hw_light, if_a.lr_light};
            rec_b[k] = {if_b.hw_light, if_b.lr_light};
`ifdef TLC_PED_EN
            rec_w[k] = if_a.ped_walk;
`else
            rec_w[k] = 1'b0;
`endif
            @(negedge clk);
        end
        car = 1'b0;
        ped = 1'b0;
    endtask

    task automatic ca(input string tag, input int k, input logic [5:0] exp);
        check(tag, {26'd0, rec_a[k]}, {26'd0, exp});
    endtask

    task automatic cb(input string tag, input int k, input logic [5:0] exp);
        check(tag, {26'd0, rec_b[k]}, {26'd0, exp});
    endtask

    initial begin
        int bad;

        // 1: no car, highway green throughout
        do_reset();
        run_seq(300, 1000, 1000, -1);
        ca("t1_c0", 0, HWG);
        bad = 0;
        for (int k = 0; k < 300; k++) if (rec_a[k] != HWG) bad++;
        check("t1_hold", bad, 0);

        // 2: car held from cycle 40
        do_reset();
        run_seq(270, 40, 1000, -1);
        ca("t2_hwg_end", 69, HWG);
        ca("t2_hwy_in", 70, HWY);
        ca("t2_hwy_end", 94, HWY);
        ca("t2_ar1", 95, ALLR);
        ca("t2_lrg_in", 96, LRG);
        ca("t2_lrg_max", 165, LRG);
        ca("t2_lry_in", 166, LRY);
        ca("t2_lry_end", 190, LRY);
        ca("t2_ar2", 191, ALLR);
        ca("t2_hwg_in", 192, HWG);
        ca("t2_hwg_hold", 261, HWG);
        ca("t2_hwy_again", 262, HWY);
        cb("t2b_lrg_end", 100, LRG);
        cb("t2b_lry_in", 101, LRY);
        cb("t2b_hwg_in", 127, HWG);

        // 3: one-cycle car pulse at cycle 80, gap-out after min green
        do_reset();
        run_seq(260, 80, 81, -1);
        ca("t3_hwg", 80, HWG);
        ca("t3_hwy_in", 81, HWY);
        ca("t3_hwy_end", 105, HWY);
        ca("t3_ar1", 106, ALLR);
        ca("t3_lrg_in", 107, LRG);
        ca("t3_lrg_end", 116, LRG);
        ca("t3_lry_in", 117, LRY);
        ca("t3_ar2", 142, ALLR);
        ca("t3_hwg_in", 143, HWG);
        ca("t3_hwg_hold", 259, HWG);

        // 4: car drops at LR_G cnt=30
        do_reset();
        run_seq(160, 0, 126, -1);
        ca("t4_lrg_c30", 126, LRG);
        ca("t4_lry_in", 127, LRY);
        cb("t4b_lrg_end", 100, LRG);
        cb("t4b_lry_in", 101, LRY);

        // 5: asynchronous reset in the middle of LR_Y
        do_reset();
        run_seq(170, 0, 1000, -1);
        ca("t5_pre_lry", 169, LRY);
        car = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("t5_async", {26'd0, if_a.hw_light, if_a.lr_light}, {26'd0, HWG});
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(80, 0, 1000, -1);
        ca("t5_hwg_hold", 69, HWG);
        ca("t5_hwy_in", 70, HWY);

`ifdef TLC_PED_EN
        // 6: pedestrian request at cycle 10, no car
        do_reset();
        run_seq(300, 1000, 1000, 10);
        ca("t6_hwg_end", 69, HWG);
        ca("t6_hwy_in", 70, HWY);
        ca("t6_ar1", 95, ALLR);
        check("t6_walk_pre", {31'd0, rec_w[95]}, 32'd0);
        ca("t6_ped_in", 96, ALLR);
        check("t6_walk_in", {31'd0, rec_w[96]}, 32'd1);
        check("t6_walk_end", {31'd0, rec_w[115]}, 32'd1);
        ca("t6_ar2", 116, ALLR);
        check("t6_walk_off", {31'd0, rec_w[116]}, 32'd0);
        ca("t6_hwg_in", 117, HWG);
        ca("t6_hwg_hold", 299, HWG);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
